// File: rtl/pulse_to_level_stretcher.sv
`default_nettype none
// ============================================================================
// pulse_to_level_stretcher: edge-qualified pulses -> timed or toggled level
// Revision: 1.0
// ============================================================================
module pulse_to_level_stretcher #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pulse_i,
  input  logic                 mode_i,
  input  logic                 retrigger_i,
  input  logic [CNT_WIDTH-1:0] hold_cycles_i,
  output logic                 level_o,
  output logic [CNT_WIDTH-1:0] remaining_o,
  output logic                 done_o,
  output logic                 overrun_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_STRETCH = 2'd1;
  localparam logic [1:0] S_TOGGLED = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 pulse_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;

  logic                 w_event;
  logic [CNT_WIDTH-1:0] w_load;

  assign w_event = pulse_i & ~pulse_q;
  // A zero hold length behaves as a one-cycle hold.
  assign w_load  = (hold_cycles_i == '0) ? '0 : hold_cycles_i - CNT_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    done_d    = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_event) begin
          level_d = 1'b1;
          if (mode_i) begin
            state_d = S_TOGGLED;
            cnt_d   = '0;
          end else begin
            state_d = S_STRETCH;
            cnt_d   = w_load;
          end
        end
      end
      S_STRETCH: begin
        if (w_event && retrigger_i) begin
          cnt_d = w_load;
        end else begin
          // An ignored event flags overrun but never disturbs the countdown.
          overrun_d = w_event;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
          end else begin
            state_d = S_IDLE;
            level_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      S_TOGGLED: begin
        if (w_event) begin
          state_d = S_IDLE;
          level_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      pulse_q   <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pulse_q   <= pulse_i;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign level_o     = level_q;
  assign remaining_o = cnt_q;
  assign done_o      = done_q;
  assign overrun_o   = overrun_q;

endmodule
`default_nettype wire
